alu_req_master: RTL and testbench



---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_rsp_fifo.sv | 63 ++++++
 rtl/alu_req_master.sv | 136 +++++++++++++
 tb/tb_alu_req_master.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU request master: opcodes, error codes,
// FSM states and the command screening rule.
package alu_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_DIV = 4'd3,
      OP_MOD = 4'd4,
      OP_POW = 4'd5,
      OP_SHR = 4'd6,
      OP_SHL = 4'd7
   } alu_op_e;

   localparam logic [1:0] ERR_NONE       = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL_OP = 2'd1;
   localparam logic [1:0] ERR_DIV_ZERO   = 2'd2;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRIVE = 1'b1
   } state_e;

   // Illegal opcode outranks divide/modulo by zero.
   function automatic logic [1:0] cmd_err(input logic [3:0] op, input logic b_zero);
      if (op[3]) return ERR_ILLEGAL_OP;
      if ((op == OP_DIV || op == OP_MOD) && b_zero) return ERR_DIV_ZERO;
      return ERR_NONE;
   endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; the head entry is read straight from the storage
// flops so the output is stable whenever the FIFO is non-empty.
module alu_rsp_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               head,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign head    = mem_q[rd_q];
   // At full a push is still taken when the head leaves on the same edge.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_req_master.sv
// Drives commands onto a combinational ALU, samples the result after a settle
// time and returns it with its tag; illegal/div-by-zero commands are answered directly.
module alu_req_master
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W  = 4,
   parameter int SETTLE = 1,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [3:0]        cmd_op,
   input  logic [TAG_W-1:0]  cmd_tag,
   output logic [DATA_W-1:0] alu_num1,
   output logic [DATA_W-1:0] alu_num2,
   output logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] alu_num3,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [1:0]        rsp_err
);

   localparam int FW     = DATA_W + TAG_W + 2;
   localparam int SCNT_W = $clog2(SETTLE+1);
   localparam int FCNT_W = $clog2(DEPTH+1);

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  num1_q, num1_d, num2_q, num2_d;
   logic [3:0]         op_q, op_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [SCNT_W-1:0]  cnt_q, cnt_d;

   logic [1:0]         err;
   logic               accept;
   logic               push;
   logic [FW-1:0]      push_data;
   logic [FW-1:0]      head;
   logic [FCNT_W-1:0]  fifo_count;
   logic               fifo_full;
   logic               fifo_empty;

   // Gating with rst keeps cmd_ready low for the whole reset pulse.
   assign cmd_ready = !rst && (state_q == S_IDLE) && (fifo_count < FCNT_W'(DEPTH));
   assign accept    = cmd_valid && cmd_ready;
   assign err       = cmd_err(cmd_op, cmd_b == '0);

   assign alu_num1  = num1_q;
   assign alu_num2  = num2_q;
   assign alu_op    = op_q;

   assign rsp_valid = !fifo_empty;
   assign rsp_data  = head[FW-1 -: DATA_W];
   assign rsp_tag   = head[2 +: TAG_W];
   assign rsp_err   = head[1:0];

   always_comb begin
      state_d   = state_q;
      num1_d    = num1_q;
      num2_d    = num2_q;
      op_d      = op_q;
      tag_d     = tag_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_data = '0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (err != ERR_NONE) begin
                  push      = 1'b1;
                  push_data = {{DATA_W{1'b0}}, cmd_tag, err};
               end else begin
                  num1_d  = cmd_a;
                  num2_d  = cmd_b;
                  op_d    = cmd_op;
                  tag_d   = cmd_tag;
                  cnt_d   = SCNT_W'(SETTLE);
                  state_d = S_DRIVE;
               end
            end
         end
         S_DRIVE: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SCNT_W'(1)) begin
               push      = 1'b1;
               push_data = {alu_num3, tag_q, ERR_NONE};
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         num1_q  <= '0;
         num2_q  <= '0;
         op_q    <= '0;
         tag_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         num1_q  <= num1_d;
         num2_q  <= num2_d;
         op_q    <= op_d;
         tag_q   <= tag_d;
         cnt_q   <= cnt_d;
      end
   end

   alu_rsp_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (rsp_ready),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Admission control guarantees every push lands in a free slot.
   assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full);

endmodule

// File: tb/tb_alu_req_master.sv
// Directed bench for alu_req_master: the bench plays the combinational ALU and
// checks responses against hand-computed values.
module tb_alu_req_master;

   localparam int DW = 32;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          cmd_valid = 1'b0, cmd_valid3 = 1'b0;
   logic          cmd_ready, cmd_ready3;
   logic [DW-1:0] cmd_a = '0, cmd_b = '0;
   logic [3:0]    cmd_op = '0;
   logic [TW-1:0] cmd_tag = '0;

   logic [DW-1:0] alu_num1, alu_num2, alu_num3;
   logic [3:0]    alu_op;
   logic [DW-1:0] alu3_num1, alu3_num2, alu3_num3;
   logic [3:0]    alu3_op;

   logic          rsp_valid, rsp_valid3;
   logic          rsp_ready = 1'b0, rsp_ready3 = 1'b0;
   logic [DW-1:0] rsp_data, rsp_data3;
   logic [TW-1:0] rsp_tag, rsp_tag3;
   logic [1:0]    rsp_err, rsp_err3;

   int unsigned   n_vec  = 0;
   int unsigned   n_miss = 0;

   logic [DW-1:0] exp_n1 = '0, exp_n2 = '0;
   logic [3:0]    exp_op = '0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [3:0]  tag;
      logic [31:0] data;
      logic [1:0]  err;
   } vec_t;

   vec_t vt [8];
   vec_t bp [5];

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic signed [31:0] sa, sb;
      logic [31:0] p;
      sa = a;
      sb = b;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a * b;
         4'd3: return (sb == 0) ? 32'd0 : 32'(sa / sb);
         4'd4: return (sb == 0) ? 32'd0 : 32'(sa % sb);
         4'd5: begin
            p = 32'd1;
            for (int unsigned i = 0; i < b && i < 64; i++) p = p * a;
            return p;
         end
         4'd6: return a >> b[4:0];
         4'd7: return a << b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   assign alu_num3  = alu_model(alu_num1, alu_num2, alu_op);
   assign alu3_num3 = alu_model(alu3_num1, alu3_num2, alu3_op);

   alu_req_master #(.DATA_W(DW), .TAG_W(TW), .SETTLE(1), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
      .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op), .alu_num3(alu_num3),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
   );

   alu_req_master #(.DATA_W(DW), .TAG_W(TW), .SETTLE(3), .DEPTH(4)) dut3 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
      .alu_num1(alu3_num1), .alu_num2(alu3_num2), .alu_op(alu3_op), .alu_num3(alu3_num3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_data(rsp_data3), .rsp_tag(rsp_tag3), .rsp_err(rsp_err3)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input vec_t v);
      cmd_a   = v.a;
      cmd_b   = v.b;
      cmd_op  = v.op;
      cmd_tag = v.tag;
   endtask

   // Present a command, wait (bounded) for acceptance, then drop cmd_valid.
   task automatic issue(input vec_t v, input string name);
      int unsigned n;
      drive_cmd(v);
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         step();
         n++;
      end
      chk({name, "_accept"}, 64'(cmd_ready), 64'(1));
      step();
      cmd_valid = 1'b0;
      if (v.err == 2'd0) begin
         exp_n1 = v.a;
         exp_n2 = v.b;
         exp_op = v.op;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int unsigned n;
      rsp_ready = 1'b1;
      issue(v, "vec");
      n = 0;
      while (!rsp_valid && n < 20) begin
         step();
         n++;
      end
      chk("vec_latency", 64'(n), (v.err == 2'd0) ? 64'(1) : 64'(0));
      chk("vec_data", 64'(rsp_data), 64'(v.data));
      chk("vec_tag", 64'(rsp_tag), 64'(v.tag));
      chk("vec_err", 64'(rsp_err), 64'(v.err));
      chk("vec_alu_num1", 64'(alu_num1), 64'(exp_n1));
      chk("vec_alu_num2", 64'(alu_num2), 64'(exp_n2));
      chk("vec_alu_op", 64'(alu_op), 64'(exp_op));
      step();
      chk("vec_drained", 64'(rsp_valid), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned k, n;
      int na, acc0, acc1, rv;
      logic acc;
      vec_t v;

      vt[0] = '{a: 32'd7,    b: 32'd5, op: 4'd0,  tag: 4'd3, data: 32'd12,       err: 2'd0};
      vt[1] = '{a: 32'd9,    b: 32'd0, op: 4'd3,  tag: 4'd1, data: 32'd0,        err: 2'd2};
      vt[2] = '{a: 32'd10,   b: 32'd3, op: 4'd4,  tag: 4'd2, data: 32'd1,        err: 2'd0};
      vt[3] = '{a: 32'd5,    b: 32'd0, op: 4'd12, tag: 4'd4, data: 32'd0,        err: 2'd1};
      vt[4] = '{a: -32'sd20, b: 32'd3, op: 4'd3,  tag: 4'd5, data: -32'sd6,      err: 2'd0};
      vt[5] = '{a: 32'd256,  b: 32'd3, op: 4'd6,  tag: 4'd6, data: 32'd32,       err: 2'd0};
      vt[6] = '{a: 32'd8,    b: 32'd0, op: 4'd4,  tag: 4'd7, data: 32'd0,        err: 2'd2};
      vt[7] = '{a: 32'd1,    b: 32'd5, op: 4'd8,  tag: 4'd0, data: 32'd0,        err: 2'd1};

      bp[0] = '{a: 32'd3,    b: 32'd10, op: 4'd1, tag: 4'd8,  data: -32'sd7,  err: 2'd0};
      bp[1] = '{a: -32'sd4,  b: 32'd6,  op: 4'd2, tag: 4'd9,  data: -32'sd24, err: 2'd0};
      bp[2] = '{a: 32'd1,    b: 32'd4,  op: 4'd7, tag: 4'd10, data: 32'd16,   err: 2'd0};
      bp[3] = '{a: 32'd2,    b: 32'd5,  op: 4'd5, tag: 4'd11, data: 32'd32,   err: 2'd0};
      bp[4] = '{a: 32'd100,  b: 32'd23, op: 4'd0, tag: 4'd12, data: 32'd123,  err: 2'd0};

      // Reset state, observed while rst is still high.
      step();
      step();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
      chk("rst_rsp_err", 64'(rsp_err), 64'(0));
      chk("rst_alu_num1", 64'(alu_num1), 64'(0));
      chk("rst_alu_num2", 64'(alu_num2), 64'(0));
      chk("rst_alu_op", 64'(alu_op), 64'(0));
      rst = 1'b0;
      #1;
      chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));
      step();

      for (int i = 0; i < 8; i++) run_vec(vt[i]);

      // Back-to-back error commands: one accepted and one popped every cycle.
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_a     = 32'd1;
      cmd_b     = 32'd0;
      cmd_op    = 4'd3;
      for (int i = 0; i < 4; i++) begin
         cmd_tag = 4'(i + 1);
         chk("b2b_ready", 64'(cmd_ready), 64'(1));
         if (i > 0) begin
            chk("b2b_valid", 64'(rsp_valid), 64'(1));
            chk("b2b_tag", 64'(rsp_tag), 64'(i));
         end
         step();
      end
      cmd_valid = 1'b0;
      chk("b2b_last_tag", 64'(rsp_tag), 64'(4));
      chk("b2b_last_err", 64'(rsp_err), 64'(2));
      step();
      chk("b2b_empty", 64'(rsp_valid), 64'(0));

      // Backpressure: fill the FIFO, check admission stops, then drain in order.
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) issue(bp[i], "bp");
      v = bp[4];
      drive_cmd(v);
      cmd_valid = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("bp_full_ready", 64'(cmd_ready), 64'(0));
         step();
      end
      rsp_ready = 1'b1;
      k = 0;
      n = 0;
      while (k < 5 && n < 40) begin
         acc = cmd_valid && cmd_ready;
         if (rsp_valid) begin
            chk("bp_tag", 64'(rsp_tag), 64'(bp[k].tag));
            chk("bp_data", 64'(rsp_data), 64'(bp[k].data));
            chk("bp_err", 64'(rsp_err), 64'(0));
            k++;
         end
         step();
         n++;
         if (acc) cmd_valid = 1'b0;
      end
      chk("bp_count", 64'(k), 64'(5));
      exp_n1 = bp[4].a;
      exp_n2 = bp[4].b;
      exp_op = bp[4].op;

      // SETTLE=3 instance: latency and accept interval.
      cmd_a      = 32'd6;
      cmd_b      = 32'd7;
      cmd_op     = 4'd2;
      cmd_tag    = 4'd13;
      rsp_ready3 = 1'b1;
      cmd_valid3 = 1'b1;
      na = 0;
      acc0 = 0;
      acc1 = 0;
      rv = -1;
      for (int c = 0; c < 30; c++) begin
         if (cmd_valid3 && cmd_ready3) begin
            if (na == 0) acc0 = c;
            else acc1 = c;
            na++;
         end
         if (rsp_valid3 && rv < 0) begin
            rv = c;
            chk("s3_data", 64'(rsp_data3), 64'(42));
            chk("s3_tag", 64'(rsp_tag3), 64'(13));
            chk("s3_err", 64'(rsp_err3), 64'(0));
         end
         step();
         if (na == 2) cmd_valid3 = 1'b0;
      end
      chk("s3_accepts", 64'(na), 64'(2));
      chk("s3_latency", 64'(rv - (acc0 + 1)), 64'(3));
      chk("s3_interval", 64'(acc1 - acc0), 64'(4));

      // Reset mid-DRIVE with one response queued: everything is flushed.
      rsp_ready = 1'b0;
      v = '{a: 32'd1, b: 32'd1, op: 4'd9, tag: 4'd14, data: 32'd0, err: 2'd1};
      issue(v, "rd_err");
      chk("rd_queued", 64'(rsp_valid), 64'(1));
      v = '{a: 32'd50, b: 32'd60, op: 4'd0, tag: 4'd15, data: 32'd110, err: 2'd0};
      issue(v, "rd_add");
      chk("rd_alu_num1", 64'(alu_num1), 64'(50));
      rst = 1'b1;
      #1;
      chk("rd_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rd_rsp_data", 64'(rsp_data), 64'(0));
      chk("rd_rsp_tag", 64'(rsp_tag), 64'(0));
      chk("rd_rsp_err", 64'(rsp_err), 64'(0));
      chk("rd_alu_num1_clr", 64'(alu_num1), 64'(0));
      chk("rd_alu_num2_clr", 64'(alu_num2), 64'(0));
      chk("rd_alu_op_clr", 64'(alu_op), 64'(0));
      chk("rd_cmd_ready", 64'(cmd_ready), 64'(0));
      step();
      rst = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rd_no_rsp", 64'(rsp_valid), 64'(0));
      end
      chk("rd_ready_after", 64'(cmd_ready), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
